// File: rtl/wavelet_core_pkg.sv
// Types and constants shared by the wavelet core host-side blocks.
package wavelet_core_pkg;

    localparam int DEFAULT_OBUFF_CELL_COUNT = 4096;

    typedef enum logic [2:0] {
        RD_IDLE,
        RD_FETCH,
        RD_LOAD,
        RD_HOLD,
        RD_FINISH
    } obuff_rd_state_t;

endpackage

// File: rtl/obuff_rd_addr_counter.sv
// obuff read address counter: latches a clipped cell count on clear, advances on cen,
// and flags the final cell so the reader never wraps past count-1.
module obuff_rd_addr_counter #(
    parameter int CELL_COUNT = 4096,
    parameter int ADDR_WIDTH = $clog2(CELL_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  cen,
    input  logic [ADDR_WIDTH:0]   count_in,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);

    localparam logic [ADDR_WIDTH:0] MAX_COUNT = (ADDR_WIDTH+1)'(CELL_COUNT);

    logic [ADDR_WIDTH:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr  <= '0;
            count <= '0;
        end else if (clear) begin
            addr  <= '0;
            count <= (count_in > MAX_COUNT) ? MAX_COUNT : count_in;
        end else if (cen) begin
            addr  <= addr + 1'b1;
        end
    end

    // Compare one bit wider than addr so the last cell of a full buffer still matches.
    assign last = ({1'b0, addr} + (ADDR_WIDTH+1)'(1)) == count;

endmodule

// File: rtl/wavelet_obuff_reader.sv
// Host-side drain engine for the wavelet core obuff: prefetches each coefficient into the
// core output register and advances one cell per host read strobe.
module wavelet_obuff_reader #(
    parameter int OUTPUT_WIDTH     = 32,
    parameter int OBUFF_CELL_COUNT = wavelet_core_pkg::DEFAULT_OBUFF_CELL_COUNT,
    parameter int OBUFF_ADDR_WIDTH = $clog2(OBUFF_CELL_COUNT)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        core_read_start,
    output logic                        clear_core_read_start,
    input  logic [OBUFF_ADDR_WIDTH:0]   obuff_valid_count,
    input  logic                        core_output_reg_en_pulse,
    input  logic                        pause_work,
    output logic                        obuff_r_en,
    output logic [OBUFF_ADDR_WIDTH-1:0] obuff_r_addr,
    input  logic [OUTPUT_WIDTH-1:0]     obuff_r_data,
    output logic [OUTPUT_WIDTH-1:0]     core_output_data,
    output logic                        core_output_valid,
    output logic                        read_busy,
    output logic                        read_done,
    output logic                        read_underrun
);
    import wavelet_core_pkg::*;

    obuff_rd_state_t state;
    logic            strobe;
    logic            last_cell;
    logic            cnt_clear;
    logic            cnt_cen;

    // A paused strobe is dropped entirely: it neither advances nor counts as an underrun.
    assign strobe    = core_output_reg_en_pulse && !pause_work;
    assign cnt_clear = !pause_work && (state == RD_IDLE) && core_read_start;
    assign cnt_cen   = strobe && (state == RD_HOLD) && !last_cell;

    obuff_rd_addr_counter #(
        .CELL_COUNT (OBUFF_CELL_COUNT),
        .ADDR_WIDTH (OBUFF_ADDR_WIDTH)
    ) u_addr_counter (
        .clk      (clk),
        .rst      (rst),
        .clear    (cnt_clear),
        .cen      (cnt_cen),
        .count_in (obuff_valid_count),
        .addr     (obuff_r_addr),
        .last     (last_cell)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= RD_IDLE;
            core_output_data  <= '0;
            core_output_valid <= 1'b0;
            read_underrun     <= 1'b0;
        end else if (!pause_work) begin
            unique case (state)
                RD_IDLE: begin
                    if (core_read_start) begin
                        read_underrun <= 1'b0;
                        state         <= (obuff_valid_count == '0) ? RD_FINISH : RD_FETCH;
                    end
                end
                RD_FETCH: begin
                    if (strobe) read_underrun <= 1'b1;
                    state <= RD_LOAD;
                end
                RD_LOAD: begin
                    core_output_data  <= obuff_r_data;
                    core_output_valid <= 1'b1;
                    if (strobe) read_underrun <= 1'b1;
                    state <= RD_HOLD;
                end
                RD_HOLD: begin
                    if (strobe) begin
                        core_output_valid <= 1'b0;
                        state             <= last_cell ? RD_FINISH : RD_FETCH;
                    end
                end
                RD_FINISH: begin
                    if (strobe) read_underrun <= 1'b1;
                    core_output_valid <= 1'b0;
                    state             <= RD_IDLE;
                end
                default: state <= RD_IDLE;
            endcase
        end
    end

    // Pulses are gated by pause so a frozen FINISH still yields exactly one pulse.
    assign obuff_r_en            = (state == RD_FETCH) && !pause_work;
    assign read_done             = (state == RD_FINISH) && !pause_work;
    assign clear_core_read_start = (state == RD_FINISH) && !pause_work;
    assign read_busy             = (state == RD_FETCH) || (state == RD_LOAD) || (state == RD_HOLD);

endmodule

// File: tb/tb_wavelet_obuff_reader.sv
// Randomized and directed bench for wavelet_obuff_reader against a behavioural drain model.
module tb_wavelet_obuff_reader;

    localparam int CELLS = 4096;
    localparam int AW    = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          core_read_start = 1'b0;
    logic          clear_core_read_start;
    logic [AW:0]   obuff_valid_count = '0;
    logic          core_output_reg_en_pulse = 1'b0;
    logic          pause_work = 1'b0;
    logic          obuff_r_en;
    logic [AW-1:0] obuff_r_addr;
    logic [31:0]   obuff_r_data = '0;
    logic [31:0]   core_output_data;
    logic          core_output_valid;
    logic          read_busy;
    logic          read_done;
    logic          read_underrun;

    always #5 clk = ~clk;

    wavelet_obuff_reader dut (
        .clk                      (clk),
        .rst                      (rst),
        .core_read_start          (core_read_start),
        .clear_core_read_start    (clear_core_read_start),
        .obuff_valid_count        (obuff_valid_count),
        .core_output_reg_en_pulse (core_output_reg_en_pulse),
        .pause_work               (pause_work),
        .obuff_r_en               (obuff_r_en),
        .obuff_r_addr             (obuff_r_addr),
        .obuff_r_data             (obuff_r_data),
        .core_output_data         (core_output_data),
        .core_output_valid        (core_output_valid),
        .read_busy                (read_busy),
        .read_done                (read_done),
        .read_underrun            (read_underrun)
    );

    // obuff contents and its synchronous read port (output holds when not enabled)
    logic [31:0] mem [CELLS];
    always @(posedge clk) if (obuff_r_en) obuff_r_data <= mem[obuff_r_addr];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: phase of the current cell (-1 idle, 0 fetch, 1 load, 2 hold, 3 finish)
    int          ph = -1;
    int          m_idx = 0;
    int          m_cnt = 0;
    logic [31:0] m_data = '0;
    bit          m_valid = 0;
    bit          m_und = 0;
    bit          m_live = 0;

    always @(posedge clk) begin
        bit strb;
        strb = core_output_reg_en_pulse && !pause_work;
        if (rst) begin
            ph = -1; m_idx = 0; m_cnt = 0; m_data = '0; m_valid = 0; m_und = 0; m_live = 1;
        end else if (!pause_work) begin
            case (ph)
                -1: if (core_read_start) begin
                        m_cnt = (obuff_valid_count > CELLS) ? CELLS : int'(obuff_valid_count);
                        m_idx = 0;
                        m_und = 0;
                        ph    = (m_cnt == 0) ? 3 : 0;
                    end
                0: begin if (strb) m_und = 1; ph = 1; end
                1: begin m_data = mem[m_idx]; m_valid = 1; if (strb) m_und = 1; ph = 2; end
                2: if (strb) begin
                       m_valid = 0;
                       if (m_idx + 1 == m_cnt) ph = 3;
                       else begin m_idx++; ph = 0; end
                   end
                3: begin if (strb) m_und = 1; m_valid = 0; ph = -1; end
                default: ph = -1;
            endcase
        end
    end

    // Per-cycle compare plus event counters used by the directed checks
    int          done_cnt = 0;
    int          clr_cnt = 0;
    int          ren_cnt = 0;
    int          last_raddr = 0;
    bit          clr_flag = 0;
    logic [31:0] cons_q [$];

    always @(negedge clk) begin
        if (m_live) begin
            chk("r_en",     obuff_r_en,            (ph == 0) && !pause_work);
            chk("r_addr",   obuff_r_addr,          m_idx);
            chk("data",     core_output_data,      m_data);
            chk("valid",    core_output_valid,     m_valid);
            chk("busy",     read_busy,             (ph >= 0) && (ph <= 2));
            chk("done",     read_done,             (ph == 3) && !pause_work);
            chk("clear",    clear_core_read_start, (ph == 3) && !pause_work);
            chk("underrun", read_underrun,         m_und);
        end
        if (read_done) done_cnt++;
        if (clear_core_read_start) clr_cnt++;
        if (obuff_r_en) begin ren_cnt++; last_raddr = obuff_r_addr; end
        if (core_output_reg_en_pulse && !pause_work && core_output_valid) cons_q.push_back(core_output_data);
        clr_flag = clear_core_read_start;
    end

    // One clock; the host config register bit drops when the clear pulse was seen.
    task automatic cyc();
        @(posedge clk);
        #2;
        if (clr_flag) core_read_start = 1'b0;
    endtask

    task automatic run_drain(input int budget, input int ps, input int pp);
        int d0, n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            core_output_reg_en_pulse = ($urandom_range(99) < ps);
            pause_work               = ($urandom_range(99) < pp);
            if (read_busy && $urandom_range(49) == 0) core_read_start = 1'b0;
            cyc();
            n++;
        end
        core_output_reg_en_pulse = 1'b0;
        pause_work = 1'b0;
        chk("drain_finished", done_cnt - d0, 1);
    endtask

    task automatic big_drain(input string nm, input logic [AW:0] vc);
        int q0, d0, bad;
        q0 = cons_q.size();
        d0 = done_cnt;
        obuff_valid_count = vc;
        core_read_start = 1'b1;
        run_drain(20000, 100, 0);
        repeat (2) cyc();
        chk({nm, "_consumed"}, cons_q.size() - q0, CELLS);
        chk({nm, "_last_addr"}, last_raddr, CELLS - 1);
        chk({nm, "_done_once"}, done_cnt - d0, 1);
        bad = 0;
        for (int k = 0; k < CELLS && q0 + k < cons_q.size(); k++)
            if (cons_q[q0 + k] !== mem[k]) bad++;
        chk({nm, "_data_seq"}, bad, 0);
    endtask

    initial begin
        int d0, c0, r0, q0, n;
        for (int i = 0; i < CELLS; i++) mem[i] = $urandom;

        repeat (3) cyc();
        chk("rst_valid", core_output_valid, 0);
        chk("rst_data",  core_output_data, 0);
        chk("rst_busy",  read_busy, 0);
        chk("rst_addr",  obuff_r_addr, 0);
        chk("rst_und",   read_underrun, 0);
        rst = 1'b0;
        repeat (2) cyc();

        // count=4, strobes spaced 5 cycles
        d0 = done_cnt; c0 = clr_cnt; q0 = cons_q.size();
        obuff_valid_count = 4;
        core_read_start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            repeat (5) cyc();
            core_output_reg_en_pulse = 1'b1;
            cyc();
            core_output_reg_en_pulse = 1'b0;
        end
        repeat (4) cyc();
        chk("t1_done",  done_cnt - d0, 1);
        chk("t1_clear", clr_cnt - c0, 1);
        chk("t1_und",   read_underrun, 0);
        chk("t1_addr",  obuff_r_addr, 3);
        chk("t1_start_cleared", core_read_start, 0);
        for (int k = 0; k < 4; k++) chk("t1_data", cons_q[q0 + k], mem[k]);

        // count=0: immediate finish, no obuff read
        d0 = done_cnt; c0 = clr_cnt; r0 = ren_cnt;
        obuff_valid_count = 0;
        core_read_start = 1'b1;
        cyc();
        chk("t2_done_now",  read_done, 1);
        chk("t2_clear_now", clear_core_read_start, 1);
        repeat (3) cyc();
        chk("t2_done", done_cnt - d0, 1);
        chk("t2_clear", clr_cnt - c0, 1);
        chk("t2_no_ren", ren_cnt - r0, 0);

        // strobe while fetching: sticky underrun, no advance
        obuff_valid_count = 2;
        core_read_start = 1'b1;
        cyc();
        core_output_reg_en_pulse = 1'b1;
        cyc();
        core_output_reg_en_pulse = 1'b0;
        chk("t3_und",  read_underrun, 1);
        chk("t3_addr", obuff_r_addr, 0);
        run_drain(300, 50, 0);
        repeat (2) cyc();
        chk("t3_sticky", read_underrun, 1);

        // pause for 3 cycles in LOAD
        q0 = cons_q.size();
        obuff_valid_count = 2;
        core_read_start = 1'b1;
        cyc();
        cyc();
        pause_work = 1'b1;
        r0 = ren_cnt;
        repeat (3) cyc();
        chk("t4_no_ren", ren_cnt - r0, 0);
        chk("t4_valid_frozen", core_output_valid, 0);
        pause_work = 1'b0;
        run_drain(300, 100, 0);
        repeat (2) cyc();
        chk("t4_n", cons_q.size() - q0, 2);
        chk("t4_d0", cons_q[q0], mem[0]);
        chk("t4_d1", cons_q[q0 + 1], mem[1]);
        chk("t4_und", read_underrun, 1);

        // reset in HOLD at addr 2
        obuff_valid_count = 4;
        core_read_start = 1'b1;
        n = 0;
        while (!(core_output_valid && obuff_r_addr == 2) && n < 100) begin
            core_output_reg_en_pulse = core_output_valid;
            cyc();
            n++;
        end
        core_output_reg_en_pulse = 1'b0;
        chk("t5_reached", n < 100, 1);
        d0 = done_cnt;
        rst = 1'b1;
        core_read_start = 1'b0;
        cyc();
        chk("t5_busy",  read_busy, 0);
        chk("t5_valid", core_output_valid, 0);
        chk("t5_data",  core_output_data, 0);
        chk("t5_addr",  obuff_r_addr, 0);
        rst = 1'b0;
        repeat (3) cyc();
        chk("t5_no_done", done_cnt - d0, 0);

        // full buffer, then an oversize count that must clip to the buffer depth
        big_drain("t6_full", 13'd4096);
        big_drain("t7_clip", 13'd5000);

        // randomized drains with random strobes and pauses
        for (int it = 0; it < 30; it++) begin
            obuff_valid_count = 13'($urandom_range(10));
            core_read_start = 1'b1;
            run_drain(2000, $urandom_range(10, 90), $urandom_range(0, 30));
            repeat ($urandom_range(1, 3)) cyc();
        end

        repeat (3) cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
